multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
Parametrised multi-cycle successor of the processor's combinational control unit. It fetches the instruction into an internal IR and sequences each instruction through an FSM (FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK). It drives register-file, ALU, mux, PC and data-memory control, and generates I/S/B/U/J immediates sign-extended to WORDSIZE. It sits between instruction memory and the datapath, with valid/ready handshakes to both memories.

Parameters:
WORDSIZE, 64, datapath word width; immediate output width.
INSTRUCTION_SIZE, 32, instruction width (fixed 32 for RISC-V).
RETIRE_WIDTH, 16, width of the retired-instruction counter.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
instruction  input  INSTRUCTION_SIZE  instruction word from instruction memory.
imem_valid  input  1  instruction word valid.
dm_ready  input  1  data memory access complete.
alu_zero  input  1  ALU result == 0 (branch compare via SUB).
cu_ir_write_en  output  1  IR latch strobe (FETCH handshake).
cu_rf_addr_a / cu_rf_addr_b / cu_rf_write_addr  output  5 each  rs1 / rs2 / rd fields from IR.
cu_rf_write_en  output  1  register-file write.
cu_immediate  output  WORDSIZE  sign-extended immediate.
cu_mux_0_sel  output  1  ALU A: 0 = rf_a, 1 = PC.
cu_mux_1_sel  output  1  ALU B: 0 = rf_b, 1 = immediate.
cu_mux_2_sel  output  2  RF write data: 00 = ALU, 01 = dmem, 10 = PC+4, 11 = immediate.
cu_alu_operation  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
cu_dm_write_en / cu_dm_read_en  output  1 each  data-memory store / load request.
cu_pc_write_en  output  1  PC update.
cu_pc_sel  output  1  0 = PC+4, 1 = PC+immediate.
cu_illegal  output  1  sticky illegal-instruction flag.
cu_retired  output  RETIRE_WIDTH  count of completed instructions; wraps to 0.

Behaviour:
- Reset (asynchronous, rst_n=0): state=FETCH, IR=0, cu_retired=0, cu_illegal=0. All enables, mux selects and cu_alu_operation are 0 while reset is held and in FETCH.
- Reset mid-instruction aborts immediately. Nothing further is written; a pending dm request drops.
- FETCH: cu_ir_write_en = imem_valid. On imem_valid, IR <= instruction and the FSM moves to DECODE. Otherwise it stays in FETCH.
- DECODE: one cycle, no enables asserted. Register addresses and immediate are valid from IR. An unsupported opcode or funct goes to TRAP.
- Supported instructions:
  - load 0000011 (any funct3).
  - store 0100011.
  - R-type 0110011: add/sub/and/or/xor/slt/sll/srl, decoded by funct3 with funct7[5] for sub; any other funct7 is illegal.
  - I-ALU 0010011: addi/xori/ori/andi/slti.
  - branch 1100011: beq 000, bne 001.
  - LUI 0110111.
  - JAL 1101111.
- EXECUTE:
  - R-type: mux_1=0, op per funct.
  - I-ALU, load, store: mux_1=1, add for address.
  - Branch: op=sub, mux_1=0. Final state for branches: cu_pc_write_en=1, cu_pc_sel = (beq & alu_zero) | (bne & ~alu_zero); next state FETCH.
- MEMORY (load/store):
  - Hold cu_dm_read_en or cu_dm_write_en high, with the EXECUTE ALU selects held, until dm_ready.
  - Store: on dm_ready assert cu_pc_write_en (pc_sel=0); next state FETCH.
  - Load: on dm_ready go to WRITEBACK.
- WRITEBACK: one cycle.
  - Write data: mux_2 = 00 for R/I, 01 for load, 11 for LUI, 10 for JAL.
  - cu_rf_write_en=1 unless rd==0, where it is suppressed.
  - cu_pc_write_en=1, with pc_sel=1 only for JAL.
  - Next state FETCH.
- Latencies without wait states: R/I/LUI/JAL = 4 cycles, load = 5, store = 4, branch = 3. A final-state cycle increments cu_retired by 1, modulo 2^RETIRE_WIDTH.
- TRAP: cu_illegal=1, all enables 0, FSM stays in TRAP until reset; cu_retired frozen.
- Immediates are built from IR and sign-extended from the top instruction bit (IR[31]) to WORDSIZE:
  - I: IR[31:20].
  - S: {IR[31:25], IR[11:7]}.
  - B: {IR[31], IR[7], IR[30:25], IR[11:8], 0}.
  - U: {IR[31:12], 12'b0}.
  - J: {IR[31], IR[19:12], IR[20], IR[30:21], 0}.
- imem_valid is ignored outside FETCH; dm_ready is ignored outside MEMORY.

Test Plan:
- add: instruction 0x007981B3, imem_valid=1 → addr_a=19, addr_b=7, write_addr=3, op=000. WRITEBACK in 4th cycle with rf_write_en=1, mux_2=00, pc_write_en=1; cu_retired=1.
- ld x3,0x6B(x7): 0x06B3B183, dm_ready held low 3 cycles → cu_immediate=0x6B, dm_read_en high 4 cycles; WRITEBACK mux_2=01.
- sd x7,-8(x19): 0xFE79BC23 → cu_immediate=0xFFFF_FFFF_FFFF_FFF8, mux_1=1, dm_write_en=1 until dm_ready; rf_write_en never asserted.
- beq x1,x2,+16: 0x00208863 → immediate=16; alu_zero=1 gives pc_sel=1, alu_zero=0 gives pc_sel=0; 3 cycles each.
- 0xFFFFFFFF → TRAP after DECODE; cu_illegal=1 persists for 10 cycles with imem_valid toggling. rst_n pulse clears it and returns to FETCH.
- Async reset asserted during load MEMORY wait → outputs 0 immediately without a clock edge; retired count unchanged at 0; counter wrap checked with RETIRE_WIDTH=2 after 4 instructions → 0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: latches the instruction into IR and sequences it
// through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, driving datapath controls,
// sign-extended immediates, an illegal-instruction trap and a retire counter.
module multicycle_control_unit #(
    parameter int WORDSIZE         = 64,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int RETIRE_WIDTH     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [INSTRUCTION_SIZE-1:0] instruction,
    input  logic                        imem_valid,
    input  logic                        dm_ready,
    input  logic                        alu_zero,
    output logic                        cu_ir_write_en,
    output logic [4:0]                  cu_rf_addr_a,
    output logic [4:0]                  cu_rf_addr_b,
    output logic [4:0]                  cu_rf_write_addr,
    output logic                        cu_rf_write_en,
    output logic [WORDSIZE-1:0]         cu_immediate,
    output logic                        cu_mux_0_sel,
    output logic                        cu_mux_1_sel,
    output logic [1:0]                  cu_mux_2_sel,
    output logic [2:0]                  cu_alu_operation,
    output logic                        cu_dm_write_en,
    output logic                        cu_dm_read_en,
    output logic                        cu_pc_write_en,
    output logic                        cu_pc_sel,
    output logic                        cu_illegal,
    output logic [RETIRE_WIDTH-1:0]     cu_retired
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    state_t                        state_q, state_d;
    logic [INSTRUCTION_SIZE-1:0]   ir_q, ir_d;
    logic [RETIRE_WIDTH-1:0]       retired_q, retired_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_load, is_store, is_rtype, is_ialu, is_branch, is_lui, is_jal;
    logic       legal;
    logic [2:0] alu_op;
    logic       retire;

    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign funct7    = ir_q[31:25];
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_rtype  = (opcode == OP_RTYPE);
    assign is_ialu   = (opcode == OP_IALU);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_lui    = (opcode == OP_LUI);
    assign is_jal    = (opcode == OP_JAL);

    assign cu_rf_addr_a     = ir_q[19:15];
    assign cu_rf_addr_b     = ir_q[24:20];
    assign cu_rf_write_addr = ir_q[11:7];
    assign cu_illegal       = (state_q == S_TRAP);
    assign cu_retired       = retired_q;

    // Opcode/funct legality check and ALU operation selection
    always_comb begin
        legal  = 1'b0;
        alu_op = ALU_ADD;
        case (opcode)
            OP_LOAD, OP_STORE, OP_LUI, OP_JAL: legal = 1'b1;
            OP_RTYPE: begin
                // funct7[5] is only meaningful for sub; everything else needs funct7 == 0
                legal = (funct7 == 7'b0000000) ||
                        (funct7 == 7'b0100000 && funct3 == 3'b000);
                case (funct3)
                    3'b000:  alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_op = ALU_AND;
                    3'b110:  alu_op = ALU_OR;
                    3'b100:  alu_op = ALU_XOR;
                    3'b010:  alu_op = ALU_SLT;
                    3'b001:  alu_op = ALU_SLL;
                    3'b101:  alu_op = ALU_SRL;
                    default: legal  = 1'b0;
                endcase
            end
            OP_IALU: begin
                legal = 1'b1;
                case (funct3)
                    3'b000:  alu_op = ALU_ADD;
                    3'b100:  alu_op = ALU_XOR;
                    3'b110:  alu_op = ALU_OR;
                    3'b111:  alu_op = ALU_AND;
                    3'b010:  alu_op = ALU_SLT;
                    default: legal  = 1'b0;
                endcase
            end
            OP_BRANCH: begin
                legal  = (funct3 == 3'b000) || (funct3 == 3'b001);
                alu_op = ALU_SUB;
            end
            default: legal = 1'b0;
        endcase
    end

    // Immediate generation, format chosen by opcode, sign-extended from IR[31]
    always_comb begin
        cu_immediate = '0;
        if (is_load || is_ialu)
            cu_immediate = {{(WORDSIZE-12){ir_q[31]}}, ir_q[31:20]};
        else if (is_store)
            cu_immediate = {{(WORDSIZE-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
        else if (is_branch)
            cu_immediate = {{(WORDSIZE-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25],
                            ir_q[11:8], 1'b0};
        else if (is_lui)
            cu_immediate = {{(WORDSIZE-32){ir_q[31]}}, ir_q[31:12], 12'b0};
        else if (is_jal)
            cu_immediate = {{(WORDSIZE-21){ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20],
                            ir_q[30:21], 1'b0};
    end

    // Next-state and control outputs per FSM state
    always_comb begin
        state_d          = state_q;
        cu_ir_write_en   = 1'b0;
        cu_rf_write_en   = 1'b0;
        cu_mux_0_sel     = 1'b0;
        cu_mux_1_sel     = 1'b0;
        cu_mux_2_sel     = 2'b00;
        cu_alu_operation = ALU_ADD;
        cu_dm_write_en   = 1'b0;
        cu_dm_read_en    = 1'b0;
        cu_pc_write_en   = 1'b0;
        cu_pc_sel        = 1'b0;
        retire           = 1'b0;
        case (state_q)
            S_FETCH: begin
                // gated by rst_n so the strobe stays low while reset is held
                cu_ir_write_en = imem_valid & rst_n;
                if (imem_valid) state_d = S_DECODE;
            end
            S_DECODE: state_d = legal ? S_EXECUTE : S_TRAP;
            S_EXECUTE: begin
                cu_mux_0_sel     = is_jal;
                cu_mux_1_sel     = is_load | is_store | is_ialu | is_jal;
                cu_alu_operation = alu_op;
                if (is_branch) begin
                    cu_pc_write_en = 1'b1;
                    cu_pc_sel      = funct3[0] ? ~alu_zero : alu_zero;
                    retire         = 1'b1;
                    state_d        = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEMORY;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                cu_mux_1_sel     = 1'b1;
                cu_alu_operation = alu_op;
                cu_dm_read_en    = is_load;
                cu_dm_write_en   = is_store;
                if (dm_ready) begin
                    if (is_store) begin
                        cu_pc_write_en = 1'b1;
                        retire         = 1'b1;
                        state_d        = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                cu_mux_0_sel     = is_jal;
                cu_mux_1_sel     = is_load | is_ialu | is_jal;
                cu_alu_operation = alu_op;
                cu_rf_write_en   = (ir_q[11:7] != 5'd0);
                cu_mux_2_sel     = is_load ? 2'b01 : is_lui ? 2'b11 : is_jal ? 2'b10 : 2'b00;
                cu_pc_write_en   = 1'b1;
                cu_pc_sel        = is_jal;
                retire           = 1'b1;
                state_d          = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // IR capture and retire counter next values
    always_comb begin
        ir_d      = cu_ir_write_en ? instruction : ir_q;
        retired_d = retire ? retired_q + RETIRE_WIDTH'(1) : retired_q;
    end

    // State, IR and retire counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle control vectors are
// queued when an instruction is issued and popped as each cycle is sampled.
module tb_multicycle_control_unit;

    typedef enum int {C_R, C_I, C_LD, C_ST, C_BR, C_LUI, C_JAL} cls_t;
    typedef struct { string tag; logic [14:0] exp; } ctrl_exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction = '0;
    logic        imem_valid = 1'b0;
    logic        dm_ready = 1'b0;
    logic        alu_zero = 1'b0;

    logic        ir_we, rf_we, mux0, mux1, dm_we, dm_re, pc_we, pc_sel, illegal;
    logic [4:0]  addr_a, addr_b, addr_d;
    logic [63:0] imm;
    logic [1:0]  mux2;
    logic [2:0]  aluop;
    logic [15:0] retired;

    logic        b_ir_we, b_rf_we, b_mux0, b_mux1, b_dm_we, b_dm_re, b_pc_we, b_pc_sel, b_illegal;
    logic [4:0]  b_addr_a, b_addr_b, b_addr_d;
    logic [63:0] b_imm;
    logic [1:0]  b_mux2;
    logic [2:0]  b_aluop;
    logic [1:0]  b_retired;

    multicycle_control_unit #(.WORDSIZE(64), .INSTRUCTION_SIZE(32), .RETIRE_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .imem_valid(imem_valid),
        .dm_ready(dm_ready), .alu_zero(alu_zero), .cu_ir_write_en(ir_we),
        .cu_rf_addr_a(addr_a), .cu_rf_addr_b(addr_b), .cu_rf_write_addr(addr_d),
        .cu_rf_write_en(rf_we), .cu_immediate(imm), .cu_mux_0_sel(mux0), .cu_mux_1_sel(mux1),
        .cu_mux_2_sel(mux2), .cu_alu_operation(aluop), .cu_dm_write_en(dm_we),
        .cu_dm_read_en(dm_re), .cu_pc_write_en(pc_we), .cu_pc_sel(pc_sel),
        .cu_illegal(illegal), .cu_retired(retired));

    multicycle_control_unit #(.WORDSIZE(64), .INSTRUCTION_SIZE(32), .RETIRE_WIDTH(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .imem_valid(imem_valid),
        .dm_ready(dm_ready), .alu_zero(alu_zero), .cu_ir_write_en(b_ir_we),
        .cu_rf_addr_a(b_addr_a), .cu_rf_addr_b(b_addr_b), .cu_rf_write_addr(b_addr_d),
        .cu_rf_write_en(b_rf_we), .cu_immediate(b_imm), .cu_mux_0_sel(b_mux0),
        .cu_mux_1_sel(b_mux1), .cu_mux_2_sel(b_mux2), .cu_alu_operation(b_aluop),
        .cu_dm_write_en(b_dm_we), .cu_dm_read_en(b_dm_re), .cu_pc_write_en(b_pc_we),
        .cu_pc_sel(b_pc_sel), .cu_illegal(b_illegal), .cu_retired(b_retired));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_ret = 0;
    ctrl_exp_t ctrl_q[$];

    logic [14:0] obs_ctrl;
    assign obs_ctrl = {ir_we, rf_we, mux0, mux1, mux2, aluop, dm_we, dm_re, pc_we, pc_sel, illegal};

    function automatic logic [14:0] cv(input logic irw, input logic rfw, input logic m0,
                                       input logic m1, input logic [1:0] m2, input logic [2:0] op,
                                       input logic dmw, input logic dmr, input logic pcw,
                                       input logic pcs, input logic ill);
        return {irw, rfw, m0, m1, m2, op, dmw, dmr, pcw, pcs, ill};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [14:0] e);
        ctrl_exp_t x;
        x.tag = tag;
        x.exp = e;
        ctrl_q.push_back(x);
    endtask

    // sample 1 time unit after the falling edge, compare against the oldest queued vector
    task automatic sample();
        ctrl_exp_t e;
        #1;
        if (ctrl_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL ctrl_queue_empty observed=0x%0h expected=queued_entry", obs_ctrl);
        end else begin
            e = ctrl_q.pop_front();
            chk(e.tag, 64'(obs_ctrl), 64'(e.exp));
        end
    endtask

    task automatic adv();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_retired(input string nm);
        chk({nm, "_retired16"}, 64'(retired), 64'(n_ret % 65536));
        chk({nm, "_retired2"}, 64'(b_retired), 64'(n_ret % 4));
    endtask

    task automatic run_instr(input string nm, input logic [31:0] ins, input cls_t c,
                             input logic [2:0] op, input int waits, input logic zero,
                             input logic [4:0] ea, input logic [4:0] eb, input logic [4:0] ed,
                             input logic [63:0] eimm);
        logic       m0, m1, taken;
        logic [1:0] m2;
        m0    = (c == C_JAL);
        m1    = (c == C_I) || (c == C_LD) || (c == C_ST) || (c == C_JAL);
        m2    = (c == C_LD) ? 2'b01 : (c == C_LUI) ? 2'b11 : (c == C_JAL) ? 2'b10 : 2'b00;
        taken = ins[12] ? ~zero : zero;

        push({nm, "_fetch"}, cv(1, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0));
        push({nm, "_decode"}, '0);
        if (c == C_BR) push({nm, "_execute"}, cv(0, 0, 0, 0, 2'b00, 3'b001, 0, 0, 1, taken, 0));
        else           push({nm, "_execute"}, cv(0, 0, m0, m1, 2'b00, op, 0, 0, 0, 0, 0));
        if (c == C_LD)
            for (int i = 0; i <= waits; i++)
                push({nm, "_memory"}, cv(0, 0, 0, 1, 2'b00, 3'b000, 0, 1, 0, 0, 0));
        if (c == C_ST) begin
            for (int i = 0; i < waits; i++)
                push({nm, "_memory"}, cv(0, 0, 0, 1, 2'b00, 3'b000, 1, 0, 0, 0, 0));
            push({nm, "_memory_done"}, cv(0, 0, 0, 1, 2'b00, 3'b000, 1, 0, 1, 0, 0));
        end
        if (c != C_BR && c != C_ST)
            push({nm, "_writeback"}, cv(0, ed != 5'd0, m0, m1, m2, op, 0, 0, 1, c == C_JAL, 0));

        instruction = ins; imem_valid = 1'b1;
        sample(); adv();
        imem_valid = 1'b0; instruction = $urandom;
        sample();
        chk({nm, "_addr_a"}, 64'(addr_a), 64'(ea));
        chk({nm, "_addr_b"}, 64'(addr_b), 64'(eb));
        chk({nm, "_addr_d"}, 64'(addr_d), 64'(ed));
        if (c != C_R) chk({nm, "_imm"}, imm, eimm);
        adv();
        alu_zero = zero;
        sample(); adv();
        if (c == C_LD || c == C_ST) begin
            dm_ready = 1'b0;
            repeat (waits) begin sample(); adv(); end
            dm_ready = 1'b1;
            sample(); adv();
            dm_ready = 1'b0;
        end
        if (c != C_BR && c != C_ST) begin sample(); adv(); end
        alu_zero = 1'b0;
        n_ret++;
        chk_retired(nm);
    endtask

    initial begin
        // reset held with imem_valid high: no IR strobe, everything cleared
        rst_n = 1'b0; imem_valid = 1'b1; instruction = 32'h007981B3;
        @(negedge clk);
        push("reset_hold", '0); sample();
        chk("reset_addr_a", 64'(addr_a), 64'd0);
        chk("reset_imm", imm, 64'd0);
        chk_retired("reset");
        adv();
        push("reset_hold2", '0); sample();
        rst_n = 1'b1; imem_valid = 1'b0;
        adv();

        run_instr("add",  32'h007981B3, C_R,   3'b000, 0, 0, 5'd19, 5'd7,  5'd3,  64'd0);
        run_instr("ld",   32'h06B3B183, C_LD,  3'b000, 3, 0, 5'd7,  5'd11, 5'd3,  64'h6B);
        run_instr("sd",   32'hFE79BC23, C_ST,  3'b000, 2, 0, 5'd19, 5'd7,  5'd24, 64'hFFFF_FFFF_FFFF_FFF8);
        run_instr("beqT", 32'h00208863, C_BR,  3'b001, 0, 1, 5'd1,  5'd2,  5'd16, 64'd16);
        run_instr("beqN", 32'h00208863, C_BR,  3'b001, 0, 0, 5'd1,  5'd2,  5'd16, 64'd16);
        run_instr("bneN", 32'h00209863, C_BR,  3'b001, 0, 1, 5'd1,  5'd2,  5'd16, 64'd16);
        run_instr("addi0",32'h00500013, C_I,   3'b000, 0, 0, 5'd0,  5'd5,  5'd0,  64'd5);
        run_instr("xori", 32'hFFF2C213, C_I,   3'b100, 0, 0, 5'd5,  5'd31, 5'd4,  64'hFFFF_FFFF_FFFF_FFFF);
        run_instr("sub",  32'h407302B3, C_R,   3'b001, 0, 0, 5'd6,  5'd7,  5'd5,  64'd0);
        run_instr("lui",  32'h800002B7, C_LUI, 3'b000, 0, 0, 5'd0,  5'd0,  5'd5,  64'hFFFF_FFFF_8000_0000);
        run_instr("jal",  32'hFFDFF0EF, C_JAL, 3'b000, 0, 0, 5'd31, 5'd29, 5'd1,  64'hFFFF_FFFF_FFFF_FFFC);

        // asynchronous reset while a load waits in MEMORY
        instruction = 32'h06B3B183; imem_valid = 1'b1;
        push("ldrst_fetch", cv(1, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0)); sample(); adv();
        imem_valid = 1'b0;
        push("ldrst_decode", '0); sample(); adv();
        push("ldrst_execute", cv(0, 0, 0, 1, 2'b00, 3'b000, 0, 0, 0, 0, 0)); sample(); adv();
        push("ldrst_mem1", cv(0, 0, 0, 1, 2'b00, 3'b000, 0, 1, 0, 0, 0)); sample(); adv();
        push("ldrst_mem2", cv(0, 0, 0, 1, 2'b00, 3'b000, 0, 1, 0, 0, 0)); sample();
        #2 rst_n = 1'b0;
        n_ret = 0;
        push("ldrst_async", '0); sample();
        chk("ldrst_addr_d", 64'(addr_d), 64'd0);
        chk_retired("ldrst");
        @(negedge clk); rst_n = 1'b1;

        run_instr("add2", 32'h007981B3, C_R, 3'b000, 0, 0, 5'd19, 5'd7, 5'd3, 64'd0);

        // illegal instruction: trap is sticky and ignores imem_valid
        instruction = 32'hFFFFFFFF; imem_valid = 1'b1;
        push("trap_fetch", cv(1, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0)); sample(); adv();
        imem_valid = 1'b0;
        push("trap_decode", '0); sample(); adv();
        for (int i = 0; i < 10; i++) begin
            imem_valid = i[0];
            push("trap_hold", cv(0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 1)); sample(); adv();
        end
        chk("trap_w2_illegal", 64'(b_illegal), 64'd1);
        chk_retired("trap");

        rst_n = 1'b0; imem_valid = 1'b0;
        push("trap_reset", '0); sample();
        n_ret = 0;
        chk_retired("trap_reset");
        @(negedge clk); rst_n = 1'b1;
        run_instr("add3", 32'h007981B3, C_R, 3'b000, 0, 0, 5'd19, 5'd7, 5'd3, 64'd0);

        if (ctrl_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL ctrl_queue_leftover observed=%0d expected=0", ctrl_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
